// File: rtl/tpu_tile_sequencer.sv
// Multi-tile matrix-multiply sequencer: pops weight tiles, strobes weight reload,
// streams UB rows and writes delayed result rows at a running SRAM address.
module tpu_tile_sequencer #(
    parameter int unsigned ADDRESSSIZE    = 10,
    parameter int unsigned ROWS_BW        = 8,
    parameter int unsigned TILES_BW       = 6,
    parameter int unsigned WLOAD_CYCLES   = 1,
    parameter int unsigned RESULT_LATENCY = 384
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDRESSSIZE-1:0] cfg_ub_base,
    input  logic [ADDRESSSIZE-1:0] cfg_res_base,
    input  logic [ROWS_BW-1:0]     cfg_rows,
    input  logic [TILES_BW-1:0]    cfg_tiles,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    output logic                   we_rl,
    output logic                   ub_rd_en,
    output logic [ADDRESSSIZE-1:0] ub_addr,
    output logic                   res_we,
    output logic [ADDRESSSIZE-1:0] res_addr,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned WCW = $clog2(WLOAD_CYCLES + 1);
    localparam logic [RESULT_LATENCY-1:0] DL_ONE  = RESULT_LATENCY'(1);
    localparam logic [RESULT_LATENCY-1:0] DL_LAST = DL_ONE << (RESULT_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, WAIT_W, WLOAD, STREAM, DRAIN} state_t;

    state_t                    state;
    logic [ADDRESSSIZE-1:0]    ub_base_q;
    logic [ROWS_BW-1:0]        rows_q;
    logic [TILES_BW-1:0]       tiles_q;
    logic [ROWS_BW-1:0]        rcnt;
    logic [TILES_BW-1:0]       tcnt;
    logic [WCW-1:0]            wcnt;
    logic [RESULT_LATENCY-1:0] dl;

    // The top stage of the delay line is the result write strobe itself.
    assign res_we = dl[RESULT_LATENCY-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            fifo_rd_en <= 1'b0;
            we_rl      <= 1'b0;
            ub_rd_en   <= 1'b0;
            ub_addr    <= '0;
            res_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ub_base_q  <= '0;
            rows_q     <= '0;
            tiles_q    <= '0;
            rcnt       <= '0;
            tcnt       <= '0;
            wcnt       <= '0;
            dl         <= '0;
        end else begin
            done <= 1'b0;
            dl   <= (dl << 1) | RESULT_LATENCY'(ub_rd_en);
            if (res_we) begin
                res_addr <= res_addr + 1'b1;
            end

            if (abort && state != IDLE) begin
                state      <= IDLE;
                fifo_rd_en <= 1'b0;
                we_rl      <= 1'b0;
                ub_rd_en   <= 1'b0;
                busy       <= 1'b0;
                dl         <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state     <= WAIT_W;
                            busy      <= 1'b1;
                            ub_base_q <= cfg_ub_base;
                            rows_q    <= cfg_rows;
                            tiles_q   <= cfg_tiles;
                            tcnt      <= '0;
                            // An empty job leaves the result address untouched.
                            if (cfg_rows != '0 && cfg_tiles != '0) begin
                                res_addr <= cfg_res_base;
                            end
                        end
                    end
                    WAIT_W: begin
                        if (rows_q == '0 || tiles_q == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (!fifo_empty) begin
                            fifo_rd_en <= 1'b1;
                            wcnt       <= '0;
                            state      <= WLOAD;
                        end
                    end
                    WLOAD: begin
                        fifo_rd_en <= 1'b0;
                        if (wcnt == WCW'(WLOAD_CYCLES)) begin
                            we_rl    <= 1'b0;
                            ub_rd_en <= 1'b1;
                            ub_addr  <= ub_base_q;
                            rcnt     <= ROWS_BW'(1);
                            state    <= STREAM;
                        end else begin
                            we_rl <= 1'b1;
                            wcnt  <= wcnt + 1'b1;
                        end
                    end
                    STREAM: begin
                        if (rcnt == rows_q) begin
                            ub_rd_en <= 1'b0;
                            state    <= DRAIN;
                        end else begin
                            ub_addr <= ub_addr + 1'b1;
                            rcnt    <= rcnt + 1'b1;
                        end
                    end
                    DRAIN: begin
                        // Only the tile's final result bit remains in the line.
                        if (dl == DL_LAST) begin
                            if (tcnt == tiles_q - 1'b1) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                tcnt  <= tcnt + 1'b1;
                                state <= WAIT_W;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Bench for tpu_tile_sequencer: directed jobs plus random jobs checked against
// a per-cycle event timeline computed from the job parameters.
module tb_tpu_tile_sequencer;

    localparam int unsigned AW  = 10;
    localparam int unsigned RBW = 8;
    localparam int unsigned TBW = 6;
    localparam int unsigned WL  = 1;
    localparam int unsigned RL  = 4;
    localparam int          N   = 512;

    logic           clk;
    logic           rstn;
    logic           start;
    logic           abort;
    logic [AW-1:0]  cfg_ub_base;
    logic [AW-1:0]  cfg_res_base;
    logic [RBW-1:0] cfg_rows;
    logic [TBW-1:0] cfg_tiles;
    logic           fifo_empty;
    logic           fifo_rd_en;
    logic           we_rl;
    logic           ub_rd_en;
    logic [AW-1:0]  ub_addr;
    logic           res_we;
    logic [AW-1:0]  res_addr;
    logic           busy;
    logic           done;

    tpu_tile_sequencer #(
        .ADDRESSSIZE   (AW),
        .ROWS_BW       (RBW),
        .TILES_BW      (TBW),
        .WLOAD_CYCLES  (WL),
        .RESULT_LATENCY(RL)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .abort       (abort),
        .cfg_ub_base (cfg_ub_base),
        .cfg_res_base(cfg_res_base),
        .cfg_rows    (cfg_rows),
        .cfg_tiles   (cfg_tiles),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .we_rl       (we_rl),
        .ub_rd_en    (ub_rd_en),
        .ub_addr     (ub_addr),
        .res_we      (res_we),
        .res_addr    (res_addr),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected timeline, indexed by cycle number relative to the start cycle.
    bit            fe     [N];
    bit            e_pop  [N];
    bit            e_we   [N];
    bit            e_ub   [N];
    bit            e_res  [N];
    bit            e_busy [N];
    bit            e_done [N];
    logic [AW-1:0] e_uba  [N];
    logic [AW-1:0] e_resa [N];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_fe(input int mode);
        for (int c = 0; c < N; c++) begin
            case (mode)
                0:       fe[c] = 1'b0;
                1:       fe[c] = (c < 9);
                default: fe[c] = (c < 300) ? ($urandom_range(0, 1) == 1) : 1'b0;
            endcase
        end
    endtask

    task automatic build_model(input logic [AW-1:0] ub_base, input logic [AW-1:0] res_base,
                               input int rows, input int tiles, output int done_c);
        int t;
        int k;
        int c;
        for (int i = 0; i < N; i++) begin
            e_pop[i] = 0; e_we[i] = 0; e_ub[i] = 0; e_res[i] = 0;
            e_busy[i] = 0; e_done[i] = 0; e_uba[i] = '0; e_resa[i] = '0;
        end
        if (rows == 0 || tiles == 0) begin
            done_c = 2;
        end else begin
            t = 1;
            for (int tile = 0; tile < tiles; tile++) begin
                k = t;
                while (fe[k] && k < N - 1) k++;
                e_pop[k + 1] = 1;
                for (int w = 0; w < int'(WL); w++) e_we[k + 2 + w] = 1;
                for (int i = 0; i < rows; i++) begin
                    c = k + 2 + int'(WL) + i;
                    e_ub[c]          = 1;
                    e_uba[c]         = ub_base + AW'(i);
                    e_res[c + RL]    = 1;
                    e_resa[c + RL]   = res_base + AW'(tile * rows + i);
                end
                t = k + 2 + int'(WL) + rows + int'(RL);
            end
            done_c = t;
        end
        e_done[done_c] = 1;
        for (int i = 1; i < done_c; i++) e_busy[i] = 1;
    endtask

    task automatic zero_from(input int cut);
        for (int i = cut; i < N; i++) begin
            e_pop[i] = 0; e_we[i] = 0; e_ub[i] = 0; e_res[i] = 0;
            e_busy[i] = 0; e_done[i] = 0;
        end
    endtask

    task automatic run_job(input logic [AW-1:0] ub_base, input logic [AW-1:0] res_base,
                           input int rows, input int tiles, input int abort_at,
                           input int rst_at, input bit rand_start, output int obs_done);
        int done_c;
        int last;
        build_model(ub_base, res_base, rows, tiles, done_c);
        if (abort_at >= 0) zero_from(abort_at + 1);
        if (rst_at >= 0) zero_from(rst_at);
        last = (abort_at >= 0) ? abort_at + 4 : (rst_at >= 0) ? rst_at + 20 : done_c + 3;
        obs_done = -1;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            start      = (c == 0) || (rand_start && e_busy[c] && ($urandom_range(0, 3) == 0));
            abort      = (c == abort_at);
            fifo_empty = fe[c];
            if (c == 0) begin
                cfg_ub_base  = ub_base;
                cfg_res_base = res_base;
                cfg_rows     = RBW'(rows);
                cfg_tiles    = TBW'(tiles);
            end else begin
                cfg_ub_base  = AW'($urandom);
                cfg_res_base = AW'($urandom);
                cfg_rows     = RBW'($urandom);
                cfg_tiles    = TBW'($urandom);
            end
            if (c == rst_at) begin
                #1 rstn = 1'b0;
            end
            if (rst_at >= 0 && c == rst_at + 2) rstn = 1'b1;
            @(negedge clk);
            check_eq($sformatf("fifo_rd_en@%0d", c), 32'(fifo_rd_en), 32'(e_pop[c]));
            check_eq($sformatf("we_rl@%0d", c),      32'(we_rl),      32'(e_we[c]));
            check_eq($sformatf("ub_rd_en@%0d", c),   32'(ub_rd_en),   32'(e_ub[c]));
            check_eq($sformatf("res_we@%0d", c),     32'(res_we),     32'(e_res[c]));
            check_eq($sformatf("busy@%0d", c),       32'(busy),       32'(e_busy[c]));
            check_eq($sformatf("done@%0d", c),       32'(done),       32'(e_done[c]));
            if (e_ub[c])  check_eq($sformatf("ub_addr@%0d", c),  32'(ub_addr),  32'(e_uba[c]));
            if (e_res[c]) check_eq($sformatf("res_addr@%0d", c), 32'(res_addr), 32'(e_resa[c]));
            if (done && obs_done < 0) obs_done = c;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int od;
        int rows;
        int tiles;
        int dc;
        int ab;
        rstn = 1'b0; start = 1'b0; abort = 1'b0; fifo_empty = 1'b0;
        cfg_ub_base = '0; cfg_res_base = '0; cfg_rows = '0; cfg_tiles = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_fifo_rd_en", 32'(fifo_rd_en), 0);
        check_eq("rst_we_rl",      32'(we_rl),      0);
        check_eq("rst_ub_rd_en",   32'(ub_rd_en),   0);
        check_eq("rst_ub_addr",    32'(ub_addr),    0);
        check_eq("rst_res_we",     32'(res_we),     0);
        check_eq("rst_res_addr",   32'(res_addr),   0);
        check_eq("rst_busy",       32'(busy),       0);
        check_eq("rst_done",       32'(done),       0);
        @(posedge clk);
        #1 rstn = 1'b1;

        set_fe(0);
        run_job(10'h010, 10'h100, 3, 2, -1, -1, 1'b1, od);
        check_eq("basic_done_cycle", od, 21);

        set_fe(1);
        run_job(10'h010, 10'h100, 3, 2, -1, -1, 1'b1, od);
        check_eq("bp_done_cycle", od, 29);

        set_fe(0);
        run_job(10'h3FE, 10'h3FF, 3, 1, -1, -1, 1'b0, od);

        run_job(10'h020, 10'h040, 3, 0, -1, -1, 1'b0, od);
        check_eq("zero_tiles_done", od, 2);
        run_job(10'h020, 10'h040, 0, 2, -1, -1, 1'b0, od);
        check_eq("zero_rows_done", od, 2);

        run_job(10'h010, 10'h100, 3, 2, 5, -1, 1'b0, od);
        check_eq("abort_no_done", od, -1);
        run_job(10'h010, 10'h100, 3, 2, -1, -1, 1'b0, od);
        check_eq("post_abort_done", od, 21);

        run_job(10'h010, 10'h100, 3, 2, 0, -1, 1'b0, od);
        check_eq("start_abort_idle", od, -1);

        run_job(10'h010, 10'h100, 3, 2, -1, 9, 1'b1, od);
        check_eq("reset_no_done", od, -1);
        run_job(10'h055, 10'h3FD, 4, 2, -1, -1, 1'b0, od);
        check_eq("post_reset_done", od, 2 + 2 * (2 + int'(WL) + 4 + int'(RL)) - 1);

        for (int j = 0; j < 30; j++) begin
            rows  = $urandom_range(0, 6);
            tiles = $urandom_range(0, 3);
            set_fe($urandom_range(0, 2));
            ab = -1;
            if ($urandom_range(0, 3) == 0) begin
                build_model('0, '0, rows, tiles, dc);
                ab = $urandom_range(1, dc - 1);
            end
            run_job(AW'($urandom), AW'($urandom), rows, tiles, ab, -1, 1'b1, od);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tpu_tile_sequencer.md
# tpu_tile_sequencer

Parametrised control sequencer for the systolic-array datapath that runs a multi-tile matrix multiply from a single start pulse. It pops one weight tile per pass from the Weight FIFO and pulses the weight-reload strobe. It then streams a configurable number of input rows out of the Unified Buffer and writes the matching result rows into the results SRAM at a running address. It replaces the fixed 5-bit result counter and fixed-length state counter, adding programmable base addresses, row/tile counts, FIFO-empty back-pressure, abort, and a done handshake.

## Interface
- ADDRESSSIZE, 10, width of UB and result SRAM addresses
- ROWS_BW, 8, width of cfg_rows
- TILES_BW, 6, width of cfg_tiles
- WLOAD_CYCLES, 1, cycles we_rl is held per tile (≥1)
- RESULT_LATENCY, 384, cycles from a ub_rd_en cycle to its result row at the SRAM write port (≥1)

- clk  in  1  clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  begin job; sampled only in IDLE
- abort  in  1  synchronous cancel; overrides start
- cfg_ub_base  in  ADDRESSSIZE  first UB row of input matrix
- cfg_res_base  in  ADDRESSSIZE  first result SRAM row
- cfg_rows  in  ROWS_BW  input rows per tile
- cfg_tiles  in  TILES_BW  number of weight tiles
- fifo_empty  in  1  Weight FIFO empty flag
- fifo_rd_en  out  1  pop one weight tile
- we_rl  out  1  weight reload strobe to systolic array
- ub_rd_en  out  1  UB read valid
- ub_addr  out  ADDRESSSIZE  UB read address
- res_we  out  1  result SRAM write enable
- res_addr  out  ADDRESSSIZE  result SRAM write address
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse

## Operation
- All outputs registered; reset value 0 for every output; state IDLE; delay line cleared.
- cfg_* captured into internal registers on the accepted start; later changes ignored until next job.
- States: IDLE, WAIT_W, WLOAD, STREAM, DRAIN.
- IDLE: start=1 and abort=0 → WAIT_W, busy=1. If captured cfg_rows==0 or cfg_tiles==0 → done=1 next cycle, return IDLE, no other output toggles.
- WAIT_W: while fifo_empty=1 stay (no pop). fifo_empty=0 → fifo_rd_en=1 for exactly one cycle, then WLOAD.
- WLOAD: we_rl=1 for WLOAD_CYCLES consecutive cycles, then STREAM.
- STREAM: ub_rd_en=1 for cfg_rows consecutive cycles; ub_addr = cfg_ub_base + i, i=0..cfg_rows-1. Each tile restarts at cfg_ub_base.
- ub_rd_en feeds a RESULT_LATENCY-deep 1-bit delay line; its output drives res_we.
- res_addr starts at cfg_res_base and increments after each res_we cycle, continuing across tiles (tile t row i → cfg_res_base + t·cfg_rows + i).
- DRAIN: wait until last res_we of the tile has been issued; then WAIT_W if tiles remain, else done=1 one cycle, busy=0 in that same cycle, → IDLE.
- Address arithmetic modulo 2^ADDRESSSIZE (wrap silently, no flag).
- abort=1 in any non-IDLE state → IDLE next cycle; all strobes low, delay line cleared (pending res_we suppressed), busy=0, no done pulse.
- start while busy: ignored. start and abort together in IDLE: abort wins, stay IDLE.
- fifo_empty rising during WLOAD/STREAM/DRAIN: no effect until next WAIT_W.

## Timing
- Cycle n = cycle after rising edge n. start high in cycle 0 → busy=1 from cycle 1 (WAIT_W).
- fifo_empty low in cycle k of WAIT_W → fifo_rd_en in cycle k+1; we_rl cycles k+2..k+1+WLOAD_CYCLES; ub_rd_en from k+2+WLOAD_CYCLES.
- res_we exactly RESULT_LATENCY cycles after each ub_rd_en cycle, same count, contiguous.
- WAIT_W of next tile begins in the cycle after the tile's last res_we.
- done in the cycle after the final res_we; earliest new start accepted in the cycle after done.
- No overlap of weight load with previous tile's drain (weight-stationary array).

## Test plan
- Basic: RESULT_LATENCY=4, WLOAD_CYCLES=1, cfg_rows=3, cfg_tiles=2, ub_base=0x010, res_base=0x100, FIFO non-empty, start cycle 0 → fifo_rd_en cycles 2,12; we_rl 3,13; ub_rd_en 4–6 and 14–16 at 0x010–0x012; res_we 8–10, 18–20 at 0x100–0x105; done cycle 21.
- Back-pressure: same config, fifo_empty=1 until cycle 9 → fifo_rd_en delayed to cycle 10, all later events shifted by 8, no pop while empty.
- Wrap: ADDRESSSIZE=4, ub_base=0xE, res_base=0xF, rows=3, tiles=1 → ub_addr 0xE,0xF,0x0; res_addr 0xF,0x0,0x1.
- Zero config: cfg_tiles=0 → done one cycle after acceptance; fifo_rd_en, we_rl, ub_rd_en, res_we stay 0.
- Abort mid-STREAM after 2 rows → next cycle busy=0, no further res_we (including pending), no done; new start then runs a full job correctly.
- Async reset asserted mid-DRAIN, released → all outputs 0 immediately, no res_we after release; start ignored while busy in basic run.
